// File: rtl/wb_uart_host_pkg.sv
// Shared definitions for the UART register-port bus initiator: register map,
// bus direction polarity, controller states and timeout counter width.
package wb_uart_host_pkg;

  localparam logic [1:0] UART_TX_ADDR       = 2'd0;
  localparam logic [1:0] UART_RX_ADDR       = 2'd1;
  localparam logic [1:0] UART_FREQ_DIV_ADDR = 2'd2;

  // This bus uses inverted direction polarity: low means write.
  localparam logic WB_WE_WRITE = 1'b0;
  localparam logic WB_WE_READ  = 1'b1;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2,
    RSP  = 2'd3
  } state_t;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Saturating handshake-phase timeout counter; expired is high once the count
// has reached TIMEOUT_CYCLES-1 and stays high until cleared.
module wb_timeout_ctr
  import wb_uart_host_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/wb_uart_host.sv
// Command-stream to UART register-bus initiator: one command becomes one full
// strobe/ack/release cycle. Timeout abort enabled by WB_UART_HOST_TIMEOUT_EN.
module wb_uart_host
  import wb_uart_host_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADDR_W         = 2,
  parameter int unsigned DATA_W         = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data_out,
  input  logic [DATA_W-1:0] wb_data_in,
  output logic              wb_we,
  output logic              wb_clk,
  output logic              wb_stb,
  input  logic              wb_ack
);

  state_t            state, state_n;
  logic              cmd_ready_n, rsp_valid_n, rsp_err_n, busy_n;
  logic              wb_we_n, wb_clk_n, wb_stb_n;
  logic [DATA_W-1:0] rsp_rdata_n, wb_data_out_n;
  logic [ADDR_W-1:0] wb_addr_n;
  logic              ctr_clr, ctr_en, expired;

`ifdef WB_UART_HOST_TIMEOUT_EN
  wb_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (ctr_clr),
    .enable  (ctr_en),
    .expired (expired)
  );
`else
  logic unused_ctr;
  assign unused_ctr = ^{ctr_clr, ctr_en};
  assign expired    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      busy        <= 1'b0;
      wb_stb      <= 1'b0;
      wb_clk      <= 1'b0;
      wb_we       <= WB_WE_READ;
      wb_addr     <= '0;
      wb_data_out <= '0;
    end else begin
      state       <= state_n;
      cmd_ready   <= cmd_ready_n;
      rsp_valid   <= rsp_valid_n;
      rsp_rdata   <= rsp_rdata_n;
      rsp_err     <= rsp_err_n;
      busy        <= busy_n;
      wb_stb      <= wb_stb_n;
      wb_clk      <= wb_clk_n;
      wb_we       <= wb_we_n;
      wb_addr     <= wb_addr_n;
      wb_data_out <= wb_data_out_n;
    end
  end

  always_comb begin
    state_n       = state;
    cmd_ready_n   = cmd_ready;
    rsp_valid_n   = rsp_valid;
    rsp_rdata_n   = rsp_rdata;
    rsp_err_n     = rsp_err;
    busy_n        = busy;
    wb_stb_n      = wb_stb;
    wb_clk_n      = wb_clk;
    wb_we_n       = wb_we;
    wb_addr_n     = wb_addr;
    wb_data_out_n = wb_data_out;
    ctr_clr       = 1'b0;
    ctr_en        = 1'b0;

    unique case (state)
      IDLE: begin
        cmd_ready_n = 1'b1;
        if (cmd_valid && cmd_ready) begin
          wb_addr_n     = cmd_addr;
          wb_data_out_n = cmd_wdata;
          wb_we_n       = cmd_write ? WB_WE_WRITE : WB_WE_READ;
          wb_stb_n      = 1'b1;
          wb_clk_n      = 1'b1;
          busy_n        = 1'b1;
          cmd_ready_n   = 1'b0;
          ctr_clr       = 1'b1;
          state_n       = REQ;
        end
      end
      REQ: begin
        if (wb_ack) begin
          rsp_rdata_n = (wb_we == WB_WE_READ) ? wb_data_in : '0;
          wb_stb_n    = 1'b0;
          wb_clk_n    = 1'b0;
          ctr_clr     = 1'b1;
          state_n     = REL;
        end else if (expired) begin
          wb_stb_n    = 1'b0;
          wb_clk_n    = 1'b0;
          rsp_err_n   = 1'b1;
          rsp_rdata_n = '0;
          rsp_valid_n = 1'b1;
          state_n     = RSP;
        end else begin
          ctr_en = 1'b1;
        end
      end
      REL: begin
        // The response is raised on the same edge that leaves REL, so RSP
        // always presents a valid response from its first cycle.
        if (!wb_ack) begin
          rsp_valid_n = 1'b1;
          state_n     = RSP;
        end else if (expired) begin
          rsp_err_n   = 1'b1;
          rsp_rdata_n = '0;
          rsp_valid_n = 1'b1;
          state_n     = RSP;
        end else begin
          ctr_en = 1'b1;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          rsp_err_n   = 1'b0;
          busy_n      = 1'b0;
          cmd_ready_n = 1'b1;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_uart_host.sv
// Randomized self-checking bench for wb_uart_host with a delayed-ack slave
// model and a transaction-level expectation model.
module tb_wb_uart_host;
  import wb_uart_host_pkg::*;

  localparam int unsigned TO = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [1:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid, rsp_ready, rsp_err, busy;
  logic [7:0] rsp_rdata;
  logic [1:0] wb_addr;
  logic [7:0] wb_data_out, wb_data_in;
  logic       wb_we, wb_clk, wb_stb, wb_ack;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  int unsigned s_delay = 0;
  bit          s_never = 1'b0;
  logic [7:0]  s_rdata = '0;
  int unsigned s_cnt   = 0;

  wb_uart_host #(.TIMEOUT_CYCLES(TO), .ADDR_W(2), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy),
    .wb_addr(wb_addr), .wb_data_out(wb_data_out), .wb_data_in(wb_data_in),
    .wb_we(wb_we), .wb_clk(wb_clk), .wb_stb(wb_stb), .wb_ack(wb_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Slave: acks s_delay cycles after it first sees stb, drops ack once stb falls.
  initial begin
    wb_ack     = 1'b0;
    wb_data_in = '0;
    forever begin
      @(posedge clk); #1;
      if (wb_stb) begin
        if (!wb_ack && !s_never) begin
          if (s_cnt >= s_delay) begin
            wb_ack     = 1'b1;
            wb_data_in = s_rdata;
          end else begin
            s_cnt++;
          end
        end
      end else begin
        wb_ack = 1'b0;
        s_cnt  = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals(input string where);
    check({where, "_cmd_ready"}, cmd_ready, 0);
    check({where, "_rsp_valid"}, rsp_valid, 0);
    check({where, "_rsp_rdata"}, rsp_rdata, 0);
    check({where, "_rsp_err"},   rsp_err, 0);
    check({where, "_busy"},      busy, 0);
    check({where, "_wb_stb"},    wb_stb, 0);
    check({where, "_wb_clk"},    wb_clk, 0);
    check({where, "_wb_we"},     wb_we, 1);
    check({where, "_wb_addr"},   wb_addr, 0);
    check({where, "_wb_data"},   wb_data_out, 0);
  endtask

  // Presents a command and returns once it has been accepted (or budget spent).
  task automatic send_cmd(input bit wr, input logic [1:0] addr, input logic [7:0] wd,
                          output bit ok);
    bit acc;
    int unsigned n = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    do begin
      acc = cmd_ready;
      tick();
      n++;
    end while (!acc && n < 50);
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom); cmd_addr = 2'($urandom); cmd_wdata = 8'($urandom);
    ok = acc;
    if (!acc) check("accept_budget", 0, 1);
  endtask

  task automatic finish_rsp(input int unsigned hold, input logic [7:0] exp_rd, input bit exp_err);
    check("rsp_rdata", rsp_rdata, exp_rd);
    check("rsp_err", rsp_err, exp_err);
    check("rsp_stb_lo", wb_stb, 0);
    check("rsp_clk_lo", wb_clk, 0);
    rsp_ready = 1'b0;
    repeat (hold) begin
      tick();
      check("hold_valid", rsp_valid, 1);
      check("hold_rdata", rsp_rdata, exp_rd);
      check("hold_err", rsp_err, exp_err);
      check("hold_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("post_valid", rsp_valid, 0);
    check("post_err", rsp_err, 0);
    check("post_busy", busy, 0);
    check("post_cmd_ready", cmd_ready, 1);
  endtask

  task automatic run_cmd(input bit wr, input logic [1:0] addr, input logic [7:0] wd,
                         input logic [7:0] rd, input int unsigned delay, input bit never,
                         input int unsigned hold);
    bit ok;
    int unsigned n = 0, stb_cycles = 0, exp_stb;
    logic [7:0] exp_rd;
    s_delay = delay; s_never = never; s_rdata = rd;
    exp_rd  = (wr || never) ? 8'h00 : rd;
    exp_stb = never ? TO : delay + 1;
    send_cmd(wr, addr, wd, ok);
    if (!ok) return;
    check("launch_stb", wb_stb, 1);
    check("launch_busy", busy, 1);
    check("launch_cmd_ready", cmd_ready, 0);
    while (!rsp_valid && n < 200) begin
      if (wb_stb) begin
        stb_cycles++;
        check("wb_addr", wb_addr, addr);
        check("wb_data_out", wb_data_out, wd);
        check("wb_we", wb_we, wr ? 0 : 1);
      end
      check("wb_clk_tracks_stb", wb_clk, wb_stb);
      tick();
      n++;
    end
    if (!rsp_valid) begin
      check("rsp_budget", 0, 1);
      return;
    end
    check("stb_cycles", stb_cycles, exp_stb);
    finish_rsp(hold, exp_rd, never);
    s_never = 1'b0;
  endtask

  initial begin
    bit ok;
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0;
    repeat (3) tick();
    check_reset_vals("rst");
    reset = 1'b0;
    tick();
    check("idle_cmd_ready", cmd_ready, 1);

    run_cmd(1'b1, UART_TX_ADDR, 8'h41, 8'hC3, 2, 1'b0, 0);
    run_cmd(1'b0, UART_RX_ADDR, 8'h00, 8'h5A, 0, 1'b0, 0);

`ifdef WB_UART_HOST_TIMEOUT_EN
    run_cmd(1'b0, UART_RX_ADDR, 8'h00, 8'h77, 0, 1'b1, 2);
`else
    s_never = 1'b1; s_delay = 0; s_rdata = 8'h77;
    send_cmd(1'b0, UART_RX_ADDR, 8'h00, ok);
    if (ok) begin
      repeat (3 * TO) begin
        check("wait_stb", wb_stb, 1);
        check("wait_no_rsp", rsp_valid, 0);
        tick();
      end
      s_never = 1'b0;
      for (int i = 0; i < 10 && !rsp_valid; i++) tick();
      check("late_ack_rsp", rsp_valid, 1);
      if (rsp_valid) finish_rsp(0, 8'h77, 1'b0);
    end
`endif

    run_cmd(1'b0, UART_FREQ_DIV_ADDR, 8'h00, 8'h9E, 1, 1'b0, 10);
    run_cmd(1'b1, UART_FREQ_DIV_ADDR, 8'h20, 8'h11, 0, 1'b0, 0);
    run_cmd(1'b1, UART_TX_ADDR, 8'h55, 8'h22, 1, 1'b0, 0);

    // Reset in the middle of a request phase.
    s_never = 1'b1;
    send_cmd(1'b1, 2'd3, 8'hA5, ok);
    tick(); tick();
    check("pre_reset_stb", wb_stb, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_vals("mid");
    s_never = 1'b0;
    repeat (3) begin
      tick();
      check("after_reset_no_rsp", rsp_valid, 0);
    end
    run_cmd(1'b1, 2'd3, 8'h3C, 8'h00, 0, 1'b0, 0);

    for (int k = 0; k < 25; k++) begin
      run_cmd(1'($urandom), 2'($urandom), 8'($urandom), 8'($urandom),
              $urandom_range(0, 4), 1'b0, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
